// File: rtl/fuzz_stim_sequencer.sv
// Stimulus sequencer for the fuzz harness: holds the DUT in reset, builds each
// input vector from a 32-bit LCG one word per cycle, presents it, pulses a step
// strobe and hands a log record to the cycle logger over valid/ready.
module fuzz_stim_sequencer #(
    parameter int IN_W       = 260,
    parameter int WORDS      = (IN_W + 31) / 32,
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] num_cycles,
    output logic             dut_rst_n,
    output logic [IN_W-1:0]  in_flat,
    output logic             step,
    output logic             log_valid,
    input  logic             log_ready,
    output logic [CNT_W-1:0] log_cyc,
    output logic             busy,
    output logic             done
);

    localparam int CMAX = (WORDS > RST_CYCLES) ? WORDS : RST_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [31:0] LCG_MUL = 32'h41C6_4E6D;
    localparam logic [31:0] LCG_INC = 32'h0000_3039;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_FILL0,
        S_LOAD0,
        S_FILL,
        S_ISSUE,
        S_LOG,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       lcg_q, lcg_d;
    logic [31:0]       lcg_next;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [IN_W-1:0]   shadow_q, shadow_d;
    logic [IN_W-1:0]   in_flat_q, in_flat_d;
    logic              dut_rst_n_q, dut_rst_n_d;

    // State and datapath registers; asynchronous reset returns everything to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lcg_q       <= '0;
            num_q       <= '0;
            cyc_q       <= '0;
            shadow_q    <= '0;
            in_flat_q   <= '0;
            dut_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lcg_q       <= lcg_d;
            num_q       <= num_d;
            cyc_q       <= cyc_d;
            shadow_q    <= shadow_d;
            in_flat_q   <= in_flat_d;
            dut_rst_n_q <= dut_rst_n_d;
        end
    end

    // Next-state logic: sequencing, LCG stepping, shadow fill and vector transfer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lcg_d       = lcg_q;
        num_d       = num_q;
        cyc_d       = cyc_q;
        shadow_d    = shadow_q;
        in_flat_d   = in_flat_q;
        dut_rst_n_d = dut_rst_n_q;
        lcg_next    = lcg_q * LCG_MUL + LCG_INC;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lcg_d       = seed;
                    num_d       = num_cycles;
                    cyc_d       = '0;
                    cnt_d       = '0;
                    dut_rst_n_d = 1'b0;
                    state_d     = S_RST;
                end
            end

            S_RST: begin
                if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    cnt_d       = '0;
                    dut_rst_n_d = 1'b1;
                    state_d     = S_FILL0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_FILL0, S_FILL: begin
                lcg_d = lcg_next;
                // Bit-wise write so the final word truncates naturally to IN_W.
                for (int unsigned b = 0; b < IN_W; b++) begin
                    if (cnt_q == CW'(b / 32)) begin
                        shadow_d[b] = lcg_next[b % 32];
                    end
                end
                if (cnt_q == CW'(WORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_FILL0) ? S_LOAD0 : S_ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_LOAD0: begin
                in_flat_d = shadow_q;
                state_d   = (num_q == '0) ? S_DONE : S_FILL;
            end

            S_ISSUE: begin
                in_flat_d = shadow_q;
                state_d   = S_LOG;
            end

            S_LOG: begin
                if (log_ready) begin
                    cyc_d   = cyc_q + 1'b1;
                    state_d = (cyc_q + 1'b1 == num_q) ? S_DONE : S_FILL;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state and registered datapath.
    always_comb begin
        dut_rst_n = dut_rst_n_q;
        in_flat   = in_flat_q;
        step      = (state_q == S_ISSUE);
        log_valid = (state_q == S_LOG);
        log_cyc   = cyc_q;
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        done      = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Directed bench for fuzz_stim_sequencer with a small software LCG model.
module tb_fuzz_stim_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [31:0]  seed = '0;
    logic [31:0]  num_cycles = '0;
    logic         dut_rst_n;
    logic [259:0] in_flat;
    logic         step;
    logic         log_valid;
    logic         log_ready = 1'b1;
    logic [31:0]  log_cyc;
    logic         busy;
    logic         done;

    int n_chk  = 0;
    int n_fail = 0;

    // Model and monitor storage
    logic [259:0] exp_vec [0:15];
    logic [259:0] iss_vec [0:15];
    int           step_at [0:15];
    logic [31:0]  hs_cyc  [0:15];
    int           n_samp, n_steps, n_hs, n_rstlow;
    bit           tmo;

    fuzz_stim_sequencer #(
        .IN_W(260), .RST_CYCLES(2), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .num_cycles(num_cycles),
        .dut_rst_n(dut_rst_n), .in_flat(in_flat), .step(step), .log_valid(log_valid),
        .log_ready(log_ready), .log_cyc(log_cyc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_model(input logic [31:0] s0, input int nvec);
        logic [31:0] s;
        s = s0;
        for (int v = 0; v < nvec; v++) begin
            exp_vec[v] = '0;
            for (int k = 0; k < 9; k++) begin
                s = s * 32'h41C64E6D + 32'h00003039;
                for (int b = 0; b < 32; b++)
                    if (32 * k + b < 260) exp_vec[v][32 * k + b] = s[b];
            end
        end
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] n);
        seed = s;
        num_cycles = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Collects observations only; called right after an accepted start.
    task automatic run_mon(input int budget, input bit inject);
        n_samp = 0; n_steps = 0; n_hs = 0; n_rstlow = 0;
        while (done !== 1'b1 && n_samp < budget) begin
            if (inject) begin
                start = (n_samp == 15 || n_samp == 21);
                seed = 32'hDEADBEEF;
                num_cycles = 32'd5;
            end
            if (step === 1'b1) begin
                if (n_steps < 16) begin
                    iss_vec[n_steps] = in_flat;
                    step_at[n_steps] = n_samp;
                end
                n_steps++;
            end
            if (log_valid === 1'b1 && log_ready === 1'b1) begin
                if (n_hs < 16) hs_cyc[n_hs] = log_cyc;
                n_hs++;
            end
            if (dut_rst_n === 1'b0) n_rstlow++;
            tick();
            n_samp++;
        end
        start = 1'b0;
        tmo = (done !== 1'b1);
    endtask

    task automatic test_reset();
        tick();
        n_chk++; if (dut_rst_n !== 1'b0) begin n_fail++; $display("FAIL rst_dut_rst_n: got %0h want 0", dut_rst_n); end
        n_chk++; if (in_flat !== 260'd0) begin n_fail++; $display("FAIL rst_in_flat: got %0h want 0", in_flat); end
        n_chk++; if (step !== 1'b0) begin n_fail++; $display("FAIL rst_step: got %0h want 0", step); end
        n_chk++; if (log_valid !== 1'b0) begin n_fail++; $display("FAIL rst_log_valid: got %0h want 0", log_valid); end
        n_chk++; if (log_cyc !== 32'd0) begin n_fail++; $display("FAIL rst_log_cyc: got %0h want 0", log_cyc); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0h want 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0h want 0", done); end
        rst = 1'b0;
        tick();
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_after_rst: got busy=%0h done=%0h want 0 0", busy, done); end
    endtask

    task automatic test_zero_steps();
        build_model(32'd0, 1);
        do_start(32'd0, 32'd0);
        n_chk++; if (dut_rst_n !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL z_rst_phase: got rst_n=%0h busy=%0h want 0 1", dut_rst_n, busy); end
        run_mon(100, 1'b0);
        n_chk++; if (tmo) begin n_fail++; $display("FAIL z_timeout: got no done want done"); end
        n_chk++; if (n_rstlow !== 2) begin n_fail++; $display("FAIL z_rst_cycles: got %0d want 2", n_rstlow); end
        n_chk++; if (n_samp !== 12) begin n_fail++; $display("FAIL z_latency: got %0d want 12", n_samp); end
        n_chk++; if (n_steps !== 0) begin n_fail++; $display("FAIL z_steps: got %0d want 0", n_steps); end
        n_chk++; if (in_flat[31:0] !== 32'h00003039) begin n_fail++; $display("FAIL z_word0: got %h want 00003039", in_flat[31:0]); end
        n_chk++; if (in_flat[63:32] !== 32'hD3DC167E) begin n_fail++; $display("FAIL z_word1: got %h want d3dc167e", in_flat[63:32]); end
        n_chk++; if (in_flat !== exp_vec[0]) begin n_fail++; $display("FAIL z_vec: got %h want %h", in_flat, exp_vec[0]); end
        n_chk++; if (dut_rst_n !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL z_done_outs: got rst_n=%0h busy=%0h want 1 0", dut_rst_n, busy); end
    endtask

    task automatic test_three_steps();
        log_ready = 1'b1;
        build_model(32'd0, 4);
        do_start(32'd0, 32'd3);
        run_mon(200, 1'b0);
        n_chk++; if (tmo) begin n_fail++; $display("FAIL t3_timeout: got no done want done"); end
        n_chk++; if (n_rstlow !== 2) begin n_fail++; $display("FAIL t3_rst_cycles: got %0d want 2", n_rstlow); end
        n_chk++; if (n_steps !== 3) begin n_fail++; $display("FAIL t3_steps: got %0d want 3", n_steps); end
        n_chk++; if (step_at[0] !== 21) begin n_fail++; $display("FAIL t3_first_step: got %0d want 21", step_at[0]); end
        n_chk++; if (step_at[1] - step_at[0] !== 11) begin n_fail++; $display("FAIL t3_gap01: got %0d want 11", step_at[1] - step_at[0]); end
        n_chk++; if (step_at[2] - step_at[1] !== 11) begin n_fail++; $display("FAIL t3_gap12: got %0d want 11", step_at[2] - step_at[1]); end
        n_chk++; if (n_hs !== 3) begin n_fail++; $display("FAIL t3_handshakes: got %0d want 3", n_hs); end
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (hs_cyc[k] !== 32'(k)) begin n_fail++; $display("FAIL t3_log_cyc%0d: got %0d want %0d", k, hs_cyc[k], k); end
            n_chk++; if (iss_vec[k] !== exp_vec[k]) begin n_fail++; $display("FAIL t3_vec%0d: got %h want %h", k, iss_vec[k], exp_vec[k]); end
        end
        n_chk++; if (n_samp !== 45) begin n_fail++; $display("FAIL t3_total: got %0d want 45", n_samp); end
        n_chk++; if (in_flat !== exp_vec[3]) begin n_fail++; $display("FAIL t3_final_vec: got %h want %h", in_flat, exp_vec[3]); end
    endtask

    task automatic test_backpressure();
        int cnt;
        log_ready = 1'b0;
        do_start(32'h00001234, 32'd2);
        cnt = 0;
        while (log_valid !== 1'b1 && cnt < 60) begin tick(); cnt++; end
        n_chk++; if (cnt !== 22) begin n_fail++; $display("FAIL bp_first_log: got %0d want 22", cnt); end
        n_chk++; if (log_cyc !== 32'd0) begin n_fail++; $display("FAIL bp_log_cyc0: got %0d want 0", log_cyc); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++; if (log_valid !== 1'b1 || log_cyc !== 32'd0 || step !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold%0d: got valid=%0h cyc=%0d step=%0h busy=%0h want 1 0 0 1", i, log_valid, log_cyc, step, busy);
            end
        end
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        n_chk++; if (log_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL bp_after_hs: got valid=%0h done=%0h want 0 0", log_valid, done); end
        cnt = 0;
        while (log_valid !== 1'b1 && cnt < 60) begin tick(); cnt++; end
        n_chk++; if (cnt !== 10) begin n_fail++; $display("FAIL bp_second_log: got %0d want 10", cnt); end
        n_chk++; if (log_cyc !== 32'd1) begin n_fail++; $display("FAIL bp_log_cyc1: got %0d want 1", log_cyc); end
        log_ready = 1'b1;
        tick();
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %0h want 1", done); end
    endtask

    task automatic test_top_bits();
        log_ready = 1'b1;
        build_model(32'd1461364854, 5);
        do_start(32'd1461364854, 32'd4);
        run_mon(200, 1'b0);
        n_chk++; if (n_steps !== 4) begin n_fail++; $display("FAIL tb_steps: got %0d want 4", n_steps); end
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (iss_vec[k][259:256] !== exp_vec[k][259:256]) begin n_fail++; $display("FAIL tb_top%0d: got %h want %h", k, iss_vec[k][259:256], exp_vec[k][259:256]); end
            n_chk++; if (iss_vec[k] !== exp_vec[k]) begin n_fail++; $display("FAIL tb_vec%0d: got %h want %h", k, iss_vec[k], exp_vec[k]); end
        end
        n_chk++; if (in_flat !== exp_vec[4]) begin n_fail++; $display("FAIL tb_final: got %h want %h", in_flat, exp_vec[4]); end
    endtask

    task automatic test_async_reset();
        int cnt;
        do_start(32'hCAFEF00D, 32'd3);
        repeat (6) tick();
        #2 rst = 1'b1;
        #1;
        n_chk++; if (busy !== 1'b0 || dut_rst_n !== 1'b0 || in_flat !== 260'd0 || log_valid !== 1'b0 || step !== 1'b0 || done !== 1'b0 || log_cyc !== 32'd0) begin
            n_fail++; $display("FAIL ar_fill: got busy=%0h rst_n=%0h in_flat=%0h want all zero", busy, dut_rst_n, in_flat);
        end
        tick();
        rst = 1'b0;
        tick();
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL ar_idle: got busy=%0h done=%0h want 0 0", busy, done); end
        log_ready = 1'b0;
        do_start(32'hCAFEF00D, 32'd3);
        cnt = 0;
        while (log_valid !== 1'b1 && cnt < 60) begin tick(); cnt++; end
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        cnt = 0;
        while (log_valid !== 1'b1 && cnt < 60) begin tick(); cnt++; end
        n_chk++; if (log_valid !== 1'b1 || log_cyc !== 32'd1) begin n_fail++; $display("FAIL ar_pre_log: got valid=%0h cyc=%0d want 1 1", log_valid, log_cyc); end
        #2 rst = 1'b1;
        #1;
        n_chk++; if (busy !== 1'b0 || dut_rst_n !== 1'b0 || in_flat !== 260'd0 || log_valid !== 1'b0 || log_cyc !== 32'd0 || done !== 1'b0) begin
            n_fail++; $display("FAIL ar_log: got busy=%0h valid=%0h cyc=%0d in_flat=%0h want all zero", busy, log_valid, log_cyc, in_flat);
        end
        tick();
        rst = 1'b0;
        tick();
        log_ready = 1'b1;
        build_model(32'hCAFEF00D, 4);
        do_start(32'hCAFEF00D, 32'd3);
        run_mon(200, 1'b0);
        n_chk++; if (n_steps !== 3 || n_hs !== 3) begin n_fail++; $display("FAIL ar_rerun_count: got steps=%0d hs=%0d want 3 3", n_steps, n_hs); end
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (iss_vec[k] !== exp_vec[k]) begin n_fail++; $display("FAIL ar_vec%0d: got %h want %h", k, iss_vec[k], exp_vec[k]); end
        end
        n_chk++; if (in_flat !== exp_vec[3]) begin n_fail++; $display("FAIL ar_final: got %h want %h", in_flat, exp_vec[3]); end
    endtask

    task automatic test_start_ignored();
        log_ready = 1'b1;
        build_model(32'h13579BDF, 3);
        do_start(32'h13579BDF, 32'd2);
        run_mon(200, 1'b1);
        n_chk++; if (n_steps !== 2) begin n_fail++; $display("FAIL si_steps: got %0d want 2", n_steps); end
        n_chk++; if (n_samp !== 34) begin n_fail++; $display("FAIL si_total: got %0d want 34", n_samp); end
        n_chk++; if (hs_cyc[1] !== 32'd1) begin n_fail++; $display("FAIL si_log_cyc1: got %0d want 1", hs_cyc[1]); end
        for (int k = 0; k < 2; k++) begin
            n_chk++; if (iss_vec[k] !== exp_vec[k]) begin n_fail++; $display("FAIL si_vec%0d: got %h want %h", k, iss_vec[k], exp_vec[k]); end
        end
        n_chk++; if (in_flat !== exp_vec[2]) begin n_fail++; $display("FAIL si_final: got %h want %h", in_flat, exp_vec[2]); end
    endtask

    task automatic test_restart_from_done();
        build_model(32'h2468ACE0, 2);
        do_start(32'h2468ACE0, 32'd1);
        n_chk++; if (busy !== 1'b1 || done !== 1'b0 || dut_rst_n !== 1'b0) begin n_fail++; $display("FAIL rd_accept: got busy=%0h done=%0h rst_n=%0h want 1 0 0", busy, done, dut_rst_n); end
        run_mon(200, 1'b0);
        n_chk++; if (n_steps !== 1 || n_samp !== 23) begin n_fail++; $display("FAIL rd_count: got steps=%0d total=%0d want 1 23", n_steps, n_samp); end
        n_chk++; if (hs_cyc[0] !== 32'd0) begin n_fail++; $display("FAIL rd_log_cyc: got %0d want 0", hs_cyc[0]); end
        n_chk++; if (iss_vec[0] !== exp_vec[0]) begin n_fail++; $display("FAIL rd_vec0: got %h want %h", iss_vec[0], exp_vec[0]); end
        n_chk++; if (in_flat !== exp_vec[1]) begin n_fail++; $display("FAIL rd_final: got %h want %h", in_flat, exp_vec[1]); end
    endtask

    task automatic test_max_count();
        log_ready = 1'b1;
        do_start(32'd5, 32'hFFFFFFFF);
        run_mon(40, 1'b0);
        n_chk++; if (!tmo || busy !== 1'b1) begin n_fail++; $display("FAIL mx_running: got done=%0h busy=%0h want 0 1", done, busy); end
        n_chk++; if (n_steps !== 2 || log_cyc !== 32'd2) begin n_fail++; $display("FAIL mx_progress: got steps=%0d cyc=%0d want 2 2", n_steps, log_cyc); end
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_steps();
        test_three_steps();
        test_backpressure();
        test_top_bits();
        test_async_reset();
        test_start_ignored();
        test_restart_from_done();
        test_max_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
